// File: rtl/sd_resp_collector_if.sv
// Handshake/bus bundle between the SD response collector, the SPI byte
// engine and the response register file.
interface sd_resp_collector_if;
    logic       start;
    logic [2:0] extra_bytes;
    logic       poll_req;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       we;
    logic [1:0] byte_sel;
    logic [7:0] byte_in;
    logic [7:0] r1;
    logic       busy;
    logic       done;
    logic       timeout_err;

    // Controller / SPI-engine side
    modport master (
        output start, extra_bytes, rx_valid, rx_data,
        input  poll_req, we, byte_sel, byte_in, r1, busy, done, timeout_err
    );

    // Collector side
    modport slave (
        input  start, extra_bytes, rx_valid, rx_data,
        output poll_req, we, byte_sel, byte_in, r1, busy, done, timeout_err
    );
endinterface

// File: rtl/sd_resp_collector.sv
// SD response collector: polls the SPI engine for the R1 token, then writes
// the trailing payload bytes MSB-first into a 32-bit byte-enable register.
module sd_resp_collector #(
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sd_resp_collector_if.slave   bus
);

    localparam int unsigned RemW     = $clog2(MAX_BYTES + 1);
    localparam logic [2:0]  MaxExtra = 3'(MAX_BYTES);
    localparam logic [7:0]  LastPoll = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReqR1,
        StWaitR1,
        StReqData,
        StWaitData,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [7:0]        poll_cnt_q, poll_cnt_d;
    logic [7:0]        r1_q, r1_d;
    logic              timeout_err_q, timeout_err_d;
    logic              we_q, we_d;
    logic [1:0]        byte_sel_q, byte_sel_d;
    logic [7:0]        byte_in_q, byte_in_d;

    // State and output registers; reset aborts any response in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rem_q         <= '0;
            poll_cnt_q    <= '0;
            r1_q          <= 8'hFF;
            timeout_err_q <= 1'b0;
            we_q          <= 1'b0;
            byte_sel_q    <= '0;
            byte_in_q     <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            poll_cnt_q    <= poll_cnt_d;
            r1_q          <= r1_d;
            timeout_err_q <= timeout_err_d;
            we_q          <= we_d;
            byte_sel_q    <= byte_sel_d;
            byte_in_q     <= byte_in_d;
        end
    end

    // Next-state logic: R1 hunt with NCR limit, then one poll per payload byte.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        poll_cnt_d    = poll_cnt_q;
        r1_d          = r1_q;
        timeout_err_d = timeout_err_q;
        we_d          = 1'b0;
        byte_sel_d    = byte_sel_q;
        byte_in_d     = byte_in_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Payloads longer than the destination register are clamped.
                    rem_d         = RemW'((bus.extra_bytes > MaxExtra) ? MaxExtra
                                                                       : bus.extra_bytes);
                    poll_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                    state_d       = StReqR1;
                end
            end
            StReqR1: state_d = StWaitR1;
            StWaitR1: begin
                if (bus.rx_valid) begin
                    if (!bus.rx_data[7]) begin
                        r1_d    = bus.rx_data;
                        state_d = (rem_q == '0) ? StDone : StReqData;
                    end else if (poll_cnt_q == LastPoll) begin
                        timeout_err_d = 1'b1;
                        r1_d          = 8'hFF;
                        state_d       = StDone;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                        state_d    = StReqR1;
                    end
                end
            end
            StReqData: state_d = StWaitData;
            StWaitData: begin
                if (bus.rx_valid) begin
                    // MSB-first: remaining count selects the lane directly.
                    we_d       = 1'b1;
                    byte_in_d  = bus.rx_data;
                    byte_sel_d = 2'(rem_q - RemW'(1));
                    rem_d      = rem_q - RemW'(1);
                    state_d    = (rem_q == RemW'(1)) ? StDone : StReqData;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.poll_req    = (state_q == StReqR1) || (state_q == StReqData);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.we          = we_q;
    assign bus.byte_sel    = byte_sel_q;
    assign bus.byte_in     = byte_in_q;
    assign bus.r1          = r1_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_resp_collector.sv
// Self-checking bench for sd_resp_collector: scoreboard of expected lane
// writes, monitor comparing each we pulse, scenario tasks for the rest.
module tb_sd_resp_collector;

    logic clk;
    logic rst_n;

    sd_resp_collector_if bus ();

    sd_resp_collector #(
        .TIMEOUT   (8),
        .MAX_BYTES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int poll_cnt = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic [9:0]  exp_q[$];   // {sel, byte}
    logic [31:0] dest;

    // Monitor: count pulses and score every lane write against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.poll_req) poll_cnt++;
            if (bus.done) done_cnt++;
            if (bus.we) begin
                logic [9:0] e;
                we_cnt++;
                checks++;
                dest[bus.byte_sel*8 +: 8] = bus.byte_in;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_we: got sel=%0d byte=%02h, required no write",
                             bus.byte_sel, bus.byte_in);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.byte_sel, bus.byte_in} !== e) begin
                        errors++;
                        $display("FAIL we_data: got sel=%0d byte=%02h, required sel=%0d byte=%02h",
                                 bus.byte_sel, bus.byte_in, e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic clear_counts();
        poll_cnt = 0;
        we_cnt   = 0;
        done_cnt = 0;
        dest     = 32'h0;
        exp_q.delete();
    endtask

    task automatic do_start(input logic [2:0] eb);
        @(posedge clk) #1;
        bus.start       = 1'b1;
        bus.extra_bytes = eb;
        @(posedge clk) #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_poll();
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.poll_req) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL poll_timeout: got no poll_req in 20 cycles, required one");
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk) #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk) #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic serve(input logic [7:0] b);
        wait_poll();
        send_byte(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({bus.poll_req, bus.we, bus.byte_sel, bus.byte_in, bus.done, bus.busy,
             bus.timeout_err, bus.r1} !== {1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL %s: got poll=%b we=%b sel=%0d byte=%02h done=%b busy=%b terr=%b r1=%02h, required 0 0 0 00 0 0 0 FF",
                     tag, bus.poll_req, bus.we, bus.byte_sel, bus.byte_in, bus.done, bus.busy,
                     bus.timeout_err, bus.r1);
        end
    endtask

    // Completion must land the cycle after the final byte and last one cycle.
    task automatic check_done_edge(input string tag);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got done=%b, required 1", tag, bus.done);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle: got done=%b busy=%b, required 0 0", tag, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_r1_only();
        clear_counts();
        do_start(3'd0);
        serve(8'hFF);
        serve(8'hFF);
        serve(8'h01);
        check_done_edge("r1_only");
        checks++;
        if (poll_cnt !== 3 || we_cnt !== 0 || bus.r1 !== 8'h01) begin
            errors++;
            $display("FAIL r1_only: got polls=%0d we=%0d r1=%02h, required 3 0 01",
                     poll_cnt, we_cnt, bus.r1);
        end
    endtask

    task automatic test_r7();
        clear_counts();
        exp_q.push_back({2'd3, 8'h00});
        exp_q.push_back({2'd2, 8'h00});
        exp_q.push_back({2'd1, 8'h01});
        exp_q.push_back({2'd0, 8'hAA});
        do_start(3'd4);
        serve(8'h01);
        serve(8'h00);
        serve(8'h00);
        serve(8'h01);
        serve(8'hAA);
        @(negedge clk);
        checks++;
        if ({bus.we, bus.done} !== 2'b11) begin
            errors++;
            $display("FAIL r7_last_we_done: got we=%b done=%b, required 1 1", bus.we, bus.done);
        end
        @(negedge clk);
        checks++;
        if (we_cnt !== 4 || poll_cnt !== 5 || bus.r1 !== 8'h01 || dest !== 32'h000001AA ||
            exp_q.size() !== 0) begin
            errors++;
            $display("FAIL r7: got we=%0d polls=%0d r1=%02h dest=%08h left=%0d, required 4 5 01 000001AA 0",
                     we_cnt, poll_cnt, bus.r1, dest, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        do_start(3'd4);
        for (int i = 0; i < 8; i++) serve(8'hFF);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.timeout_err !== 1'b1 || bus.r1 !== 8'hFF) begin
            errors++;
            $display("FAIL timeout_flags: got done=%b terr=%b r1=%02h, required 1 1 FF",
                     bus.done, bus.timeout_err, bus.r1);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (poll_cnt !== 8 || we_cnt !== 0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_count: got polls=%0d we=%0d busy=%b terr=%b, required 8 0 0 1",
                     poll_cnt, we_cnt, bus.busy, bus.timeout_err);
        end
        // Next accepted start clears the sticky error.
        clear_counts();
        do_start(3'd0);
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.poll_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: got terr=%b poll=%b, required 0 1",
                     bus.timeout_err, bus.poll_req);
        end
        send_byte(8'h00);
        check_done_edge("timeout_recover");
    endtask

    task automatic test_protocol();
        clear_counts();
        send_byte(8'h00);  // stray byte while idle
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || poll_cnt !== 0 || we_cnt !== 0 || bus.r1 !== 8'h00) begin
            errors++;
            $display("FAIL idle_rx: got busy=%b polls=%0d we=%0d r1=%02h, required 0 0 0 00",
                     bus.busy, poll_cnt, we_cnt, bus.r1);
        end
        exp_q.push_back({2'd0, 8'h5A});
        do_start(3'd1);
        wait_poll();
        do_start(3'd4);    // ignored while busy
        repeat (3) @(negedge clk);
        checks++;
        if (poll_cnt !== 1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got polls=%0d busy=%b, required 1 1", poll_cnt, bus.busy);
        end
        send_byte(8'h04);
        serve(8'h5A);
        check_done_edge("protocol");
        checks++;
        if (we_cnt !== 1 || poll_cnt !== 2 || bus.r1 !== 8'h04) begin
            errors++;
            $display("FAIL protocol: got we=%0d polls=%0d r1=%02h, required 1 2 04",
                     we_cnt, poll_cnt, bus.r1);
        end
    endtask

    task automatic test_clamp();
        clear_counts();
        exp_q.push_back({2'd3, 8'h11});
        exp_q.push_back({2'd2, 8'h22});
        exp_q.push_back({2'd1, 8'h33});
        exp_q.push_back({2'd0, 8'h44});
        do_start(3'd6);
        serve(8'h00);
        serve(8'h11);
        serve(8'h22);
        serve(8'h33);
        serve(8'h44);
        check_done_edge("clamp");
        checks++;
        if (we_cnt !== 4 || poll_cnt !== 5 || dest !== 32'h11223344) begin
            errors++;
            $display("FAIL clamp: got we=%0d polls=%0d dest=%08h, required 4 5 11223344",
                     we_cnt, poll_cnt, dest);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        exp_q.push_back({2'd3, 8'hDE});
        exp_q.push_back({2'd2, 8'hAD});
        do_start(3'd4);
        serve(8'h00);
        serve(8'hDE);
        serve(8'hAD);
        @(negedge clk);    // second we visible here
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (we_cnt !== 2 || poll_cnt !== 4 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got we=%0d polls=%0d busy=%b, required 2 4 0",
                     we_cnt, poll_cnt, bus.busy);
        end
        clear_counts();
        exp_q.push_back({2'd3, 8'hCA});
        exp_q.push_back({2'd2, 8'hFE});
        exp_q.push_back({2'd1, 8'hBA});
        exp_q.push_back({2'd0, 8'hBE});
        do_start(3'd4);
        serve(8'h00);
        serve(8'hCA);
        serve(8'hFE);
        serve(8'hBA);
        serve(8'hBE);
        check_done_edge("reset_rerun");
        checks++;
        if (we_cnt !== 4 || dest !== 32'hCAFEBABE || bus.r1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_rerun: got we=%0d dest=%08h r1=%02h, required 4 CAFEBABE 00",
                     we_cnt, dest, bus.r1);
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.extra_bytes = 3'd0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        dest            = 32'h0;
        test_reset();
        test_r1_only();
        test_r7();
        test_timeout();
        test_protocol();
        test_clamp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_resp_collector.md
Name: sd_resp_collector

Overview:
- Receive-side stage that pulls SD response bytes from the SPI byte engine.
- Locates the R1 token, then writes the trailing payload bytes one at a time into the 32-bit byte-enable register, using its we/byte_sel/byte_in port.
- Covers R1 responses and 32-bit payloads: OCR for R3, echo for R7.
- Sits between the SPI shifter and the argument/response register file.

Parameters:
- TIMEOUT, 8: maximum number of polled bytes while hunting for R1 (NCR limit), 1..255.
- MAX_BYTES, 4: payload capacity in bytes; matches the 32-bit destination register.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begin response collection; honoured only in IDLE.
- extra_bytes  input  3  payload bytes following R1 (0 = plain R1, 4 = R3/R7); sampled on start.
- poll_req  output  1  one-cycle request to the SPI engine to clock one 0xFF byte.
- rx_valid  input  1  one-cycle strobe; rx_data holds the received byte.
- rx_data  input  8  received byte.
- we  output  1  write strobe to the byte-enable register.
- byte_sel  output  2  destination byte lane.
- byte_in  output  8  byte to write.
- r1  output  8  captured R1 token.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- timeout_err  output  1  sticky until next accepted start; R1 not found within TIMEOUT bytes.

Behaviour:
- Reset (async, rst_n low): state IDLE; poll_req=0, we=0, byte_sel=0, byte_in=0, done=0, busy=0, timeout_err=0, r1=8'hFF, counters=0.
- Reset mid-operation aborts immediately. No partial write completes after release. Release returns to IDLE.
- All outputs are registered. busy and done decode from the registered state.

States: IDLE, REQ_R1, WAIT_R1, REQ_DATA, WAIT_DATA, DONE.
- IDLE:
  - On start: latch rem = min(extra_bytes, MAX_BYTES); clear poll_cnt and timeout_err; go to REQ_R1.
  - start is ignored in every other state.
- REQ_R1: poll_req=1 for exactly this one cycle; go to WAIT_R1.
- WAIT_R1: wait indefinitely for rx_valid. On rx_valid:
  - If rx_data[7]==0: r1<=rx_data; go to DONE if rem==0, else REQ_DATA.
  - Else if poll_cnt==TIMEOUT-1: timeout_err<=1; r1<=8'hFF; go to DONE with no payload writes.
  - Else: poll_cnt++; go to REQ_R1.
- REQ_DATA: poll_req=1 for one cycle; go to WAIT_DATA.
- WAIT_DATA: on rx_valid at cycle N:
  - At N+1: we=1, byte_in=rx_data, byte_sel=rem-1. Payload is MSB-first, so the first of 4 bytes goes to lane 3.
  - rem--; go to DONE if the new rem==0, else REQ_DATA.
- DONE: done=1 for one cycle; go to IDLE. The final we and done are high in the same cycle.
- rx_valid is ignored in IDLE, REQ_R1, REQ_DATA and DONE. At most one poll is outstanding.
- Latency:
  - rx_valid to we: 1 cycle.
  - rx_valid to the next poll_req: 1 cycle.
  - start to the first poll_req: 1 cycle.
- we never asserts for more than one cycle per received byte. Lanes are never written twice in one response.
- extra_bytes values 5..7 clamp to MAX_BYTES.
- R1 error bits are not interpreted; payload is collected regardless.

Test Plan:
- R1 only: start with extra_bytes=0; feed 0xFF,0xFF,0x01 on successive polls -> 3 poll_req pulses, r1=0x01, no we, done 1 cycle after the third rx_valid, busy drops the cycle after done.
- R7: start with extra_bytes=4; feed 0x01,0x00,0x00,0x01,0xAA -> four we pulses with (sel,byte) = (3,0x00),(2,0x00),(1,0x01),(0,0xAA); r1=0x01; destination register reads 0x000001AA.
- Timeout: TIMEOUT=8; return 0xFF to every poll -> exactly 8 poll_req, timeout_err=1, r1=0xFF, no we, done pulse. The next start clears timeout_err.
- Protocol: start pulsed while busy, and rx_valid injected while in IDLE -> no state change, no extra poll_req, no we.
- Clamp and reset: extra_bytes=6 -> exactly 4 writes to lanes 3..0. In a separate run, drop rst_n after the second we -> all outputs go to reset values asynchronously and no further we. After release, a new start runs a clean response.
